// File: rtl/coef_matmul_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coef_matmul_seq_pkg
//  Purpose  : Shared definitions for the coefficient matrix-vector sequencer,
//             coefficient loader and MAC array: geometry constants, sequencer
//             state encoding and packed coefficient word layout.
//  Revision : 1.0  initial release
// ============================================================================
package coef_matmul_seq_pkg;

    // Matrix geometry: columns per product and packed words per column
    localparam int C_N_COL  = 4;
    localparam int C_WPC    = 4;

    // Address and column-index widths matching the geometry above
    localparam int C_ADDR_W = 4;
    localparam int C_COL_W  = 2;

    // Packed word layout: two 7-bit coefficients per 14-bit word
    //   hi half = row 2i, lo half = row 2i+1
    localparam int C_COEF_W = 7;
    localparam int C_WORD_W = 2 * C_COEF_W;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_EMIT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Coefficient for the even row held in a packed word
    function automatic logic [C_COEF_W-1:0] coef_hi(input logic [C_WORD_W-1:0] word);
        return word[C_WORD_W-1 -: C_COEF_W];
    endfunction

    // Coefficient for the odd row held in a packed word
    function automatic logic [C_COEF_W-1:0] coef_lo(input logic [C_WORD_W-1:0] word);
        return word[C_COEF_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_matmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : coef_matmul_seq
//  Purpose  : Sequences a column-wise matrix-vector product. After the
//             coefficient loader signals done, it reads each column's packed
//             coefficient words together with the input-vector words, steers
//             the external MAC (clear / enable), and hands each column result
//             downstream on a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module coef_matmul_seq
    import coef_matmul_seq_pkg::*;
#(
    parameter int N_COL  = C_N_COL,
    parameter int WPC    = C_WPC,
    parameter int ADDR_W = C_ADDR_W,
    parameter int COL_W  = C_COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_done,
    input  logic              start,
    output logic              coef_rd,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              in_rd,
    output logic [ADDR_W-1:0] in_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [COL_W-1:0]  res_col,
    output logic              busy,
    output logic              done
);

    // Word-within-column counter width; at least one bit
    localparam int K_W = (WPC > 1) ? $clog2(WPC) : 1;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic                r_pending;
    logic [COL_W-1:0]    r_col;
    logic [K_W-1:0]      r_k;

    logic                r_coef_rd;
    logic [ADDR_W-1:0]   r_coef_addr;
    logic [ADDR_W-1:0]   r_in_addr;
    logic                r_mac_clr;
    logic                r_mac_en;
    logic                r_res_valid;
    logic [COL_W-1:0]    r_res_col;
    logic                r_busy;
    logic                r_done;

    // ------------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------------
    logic [K_W-1:0]      w_k_next;
    logic [ADDR_W-1:0]   w_col_base;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_last_k;
    logic                w_last_col;
    logic                w_launch;
    logic                w_abort;

    assign w_k_next    = r_k + K_W'(1);
    assign w_col_base  = ADDR_W'(r_col) * ADDR_W'(WPC);
    assign w_addr_next = w_col_base + ADDR_W'(w_k_next);
    assign w_last_k    = (r_k == K_W'(WPC - 1));
    assign w_last_col  = (r_col == COL_W'(N_COL - 1));

    // A run starts on a fresh request or a remembered one once memory is valid
    assign w_launch    = (start || r_pending) && load_done;

    // Losing the coefficient memory mid-run invalidates everything in flight
    assign w_abort     = r_busy && !load_done;

    // ------------------------------------------------------------------------
    // Sequencer: state, counters and all registered strobes in one place
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_col       <= '0;
            r_k         <= '0;
            r_coef_rd   <= 1'b0;
            r_coef_addr <= '0;
            r_in_addr   <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Single-cycle strobes default low; mac_en trails the read strobe
            // by one cycle so it lines up with synchronous memory data.
            r_mac_clr <= 1'b0;
            r_done    <= 1'b0;
            r_mac_en  <= r_coef_rd;

            if (w_abort) begin
                // Drop every strobe at once; a presented result is withdrawn
                r_state     <= ST_IDLE;
                r_pending   <= 1'b0;
                r_col       <= '0;
                r_k         <= '0;
                r_coef_rd   <= 1'b0;
                r_coef_addr <= '0;
                r_in_addr   <= '0;
                r_mac_en    <= 1'b0;
                r_res_valid <= 1'b0;
                r_res_col   <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_launch) begin
                            r_state   <= ST_CLR;
                            r_pending <= 1'b0;
                            r_col     <= '0;
                            r_busy    <= 1'b1;
                            r_mac_clr <= 1'b1;
                        end else if (start) begin
                            // Memory not ready yet: remember the request
                            r_pending <= 1'b1;
                        end
                    end

                    ST_CLR: begin
                        // Accumulator cleared this cycle; first read goes out next
                        r_state     <= ST_FETCH;
                        r_k         <= '0;
                        r_coef_rd   <= 1'b1;
                        r_coef_addr <= w_col_base;
                        r_in_addr   <= '0;
                    end

                    ST_FETCH: begin
                        if (w_last_k) begin
                            r_state     <= ST_DRAIN;
                            r_coef_rd   <= 1'b0;
                            r_coef_addr <= '0;
                            r_in_addr   <= '0;
                        end else begin
                            r_k         <= w_k_next;
                            r_coef_addr <= w_addr_next;
                            r_in_addr   <= ADDR_W'(w_k_next);
                        end
                    end

                    ST_DRAIN: begin
                        // Last word is being accumulated; result valid next cycle
                        r_state     <= ST_EMIT;
                        r_res_valid <= 1'b1;
                        r_res_col   <= r_col;
                    end

                    ST_EMIT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            r_res_col   <= '0;
                            if (w_last_col) begin
                                r_state <= ST_FIN;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= ST_CLR;
                                r_col     <= r_col + COL_W'(1);
                                r_mac_clr <= 1'b1;
                            end
                        end
                    end

                    ST_FIN: begin
                        // done pulse is on its way out; requests here are dropped
                        r_state <= ST_IDLE;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs; the input RAM is read in lockstep with coefficient memory
    // ------------------------------------------------------------------------
    assign coef_rd   = r_coef_rd;
    assign in_rd     = r_coef_rd;
    assign coef_addr = r_coef_addr;
    assign in_addr   = r_in_addr;
    assign mac_clr   = r_mac_clr;
    assign mac_en    = r_mac_en;
    assign res_valid = r_res_valid;
    assign res_col   = r_res_col;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_coef_matmul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coef_matmul_seq
//  Purpose  : Self-checking bench for coef_matmul_seq: table-driven runs with
//             per-column back-pressure, hand-written pending / abort / reset
//             sequences and randomized runs against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coef_matmul_seq;

    localparam int N_COL = 4;
    localparam int WPC   = 4;

    logic       clk;
    logic       rst;
    logic       load_done;
    logic       start;
    logic       res_ready;
    logic       coef_rd;
    logic [3:0] coef_addr;
    logic       in_rd;
    logic [3:0] in_addr;
    logic       mac_clr;
    logic       mac_en;
    logic       res_valid;
    logic [1:0] res_col;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    coef_matmul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .load_done (load_done),
        .start     (start),
        .coef_rd   (coef_rd),
        .coef_addr (coef_addr),
        .in_rd     (in_rd),
        .in_addr   (in_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_col   (res_col),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous properties: mac_en is last cycle's read strobe (unless the
    // run was aborted on that edge), and clear/enable never overlap.
    logic cap_rd, cap_abort, cap_rst;
    always @(posedge clk) begin
        cap_rd    <= coef_rd;
        cap_abort <= busy && !load_done;
        cap_rst   <= rst;
    end
    always @(negedge clk) begin
        if (mon_on && !rst && !cap_rst) begin
            chk("mac_en_delay", {31'd0, mac_en}, {31'd0, cap_rd && !cap_abort});
            chk("clr_en_excl", {31'd0, mac_clr && mac_en}, 32'd0);
        end
    end

    // One full product. Called right after a negedge. stall[c] = cycles that
    // res_ready is held low on column c; inj = cycle at which a stray start is
    // raised mid-run (0 = none); exp_done = cycle of the done pulse counted
    // from the edge that accepts the request.
    task automatic run_product(input logic [3:0][3:0] stall, input int exp_done,
                               input int inj, input bit do_start, input string tag);
        int  addr_q[$];
        int  cyc, col_exp, nclr, nen, left, ea;
        bit  seen_done, hold_v;
        logic [1:0] hold_col;
        for (int c = 0; c < N_COL; c++)
            for (int k = 0; k < WPC; k++)
                addr_q.push_back(c * WPC + k);
        cyc = 0; col_exp = 0; nclr = 0; nen = 0; left = int'(stall[0]);
        seen_done = 1'b0; hold_v = 1'b0; hold_col = 2'd0;
        res_ready = 1'b1;
        start = do_start;
        while (!seen_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj);
            if (cyc == 1) chk({tag, "_clr_first"}, {31'd0, mac_clr}, 32'd1);
            chk({tag, "_in_rd"}, {31'd0, in_rd}, {31'd0, coef_rd});
            chk({tag, "_busy"}, {31'd0, busy}, {31'd0, cyc < exp_done});
            if (coef_rd) begin
                if (addr_q.size() == 0) begin
                    chk({tag, "_extra_read"}, 32'd1, 32'd0);
                end else begin
                    ea = addr_q.pop_front();
                    chk({tag, "_coef_addr"}, {28'd0, coef_addr}, ea);
                    chk({tag, "_in_addr"}, {28'd0, in_addr}, ea % WPC);
                end
            end
            if (mac_clr) nclr++;
            if (mac_en)  nen++;
            if (hold_v) begin
                chk({tag, "_valid_hold"}, {31'd0, res_valid}, 32'd1);
                chk({tag, "_col_hold"}, {30'd0, res_col}, {30'd0, hold_col});
                chk({tag, "_rd_in_stall"}, {31'd0, coef_rd}, 32'd0);
            end
            if (res_valid) begin
                chk({tag, "_res_col"}, {30'd0, res_col}, col_exp);
                if (left > 0) begin
                    res_ready = 1'b0;
                    left--;
                    hold_v = 1'b1;
                    hold_col = res_col;
                end else begin
                    res_ready = 1'b1;
                    hold_v = 1'b0;
                    col_exp++;
                    left = (col_exp < N_COL) ? int'(stall[col_exp]) : 0;
                end
            end else begin
                res_ready = 1'b1;
                hold_v = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                chk({tag, "_done_cycle"}, cyc, exp_done);
            end
        end
        if (!seen_done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        chk({tag, "_cols"}, col_exp, N_COL);
        chk({tag, "_reads_left"}, addr_q.size(), 32'd0);
        chk({tag, "_clr_count"}, nclr, N_COL);
        chk({tag, "_en_count"}, nen, N_COL * WPC);
        // A request presented while done is pulsing must be dropped
        start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_fin_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_fin_clr"}, {31'd0, mac_clr}, 32'd0);
        end
    endtask

    typedef struct packed {
        logic [3:0][3:0] stall;
        logic [7:0]      exp_done;
        logic [7:0]      inj;
    } vec_t;

    vec_t            vecs[5];
    logic [3:0][3:0] rstall;
    int              rdone;
    bit              found;

    initial begin
        vecs[0] = '{16'h0000, 8'd29, 8'd0};   // plain run
        vecs[1] = '{16'h0300, 8'd32, 8'd0};   // 3-cycle stall on column 2
        vecs[2] = '{16'h1000, 8'd30, 8'd10};  // stall col 3, stray start mid-run
        vecs[3] = '{16'h2010, 8'd32, 8'd3};   // stalls on cols 1 and 3
        vecs[4] = '{16'h1111, 8'd33, 8'd25};  // one stall on every column

        rst = 1'b0; load_done = 1'b0; start = 1'b0; res_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_outputs", {12'd0, coef_rd, in_rd, coef_addr, in_addr, mac_clr,
                              mac_en, res_valid, res_col, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_hold", {12'd0, coef_rd, in_rd, coef_addr, in_addr, mac_clr,
                           mac_en, res_valid, res_col, busy, done}, 32'd0);
        #2 rst = 1'b0;
        load_done = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int i = 0; i < 5; i++)
            run_product(vecs[i].stall, int'(vecs[i].exp_done), int'(vecs[i].inj), 1'b1, $sformatf("vec%0d", i));

        // Request before memory is valid: held pending, launched after rise
        load_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk("pend_busy", {31'd0, busy}, 32'd0);
            chk("pend_clr", {31'd0, mac_clr}, 32'd0);
            if (j < 4) @(negedge clk);
        end
        load_done = 1'b1;
        run_product(16'h0000, 29, 0, 1'b0, "pend");

        // Abort: load_done drops on column 1's first fetch cycle
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_pre_rd", {31'd0, coef_rd}, 32'd1);
        chk("abort_pre_addr", {28'd0, coef_addr}, 32'd4);
        load_done = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {27'd0, coef_rd, in_rd, mac_en, mac_clr, res_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        load_done = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("abort_pending_clr", {31'd0, busy}, 32'd0);
        end
        run_product(16'h0000, 29, 0, 1'b1, "after_abort");

        // Reset while column 3 is presented and stalled
        start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (res_valid && res_col == 2'd3) begin
                res_ready = 1'b0;
                found = 1'b1;
            end
        end
        chk("rst_reach_col3", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {12'd0, coef_rd, in_rd, coef_addr, in_addr, mac_clr,
                          mac_en, res_valid, res_col, busy, done}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("rst_idle", {29'd0, done, busy, res_valid}, 32'd0);
        end

        // Randomized runs against the schedule model
        for (int r = 0; r < 4; r++) begin
            rdone = 1;
            for (int c = 0; c < N_COL; c++) begin
                rstall[c] = 4'($urandom_range(0, 3));
                rdone += 1 + WPC + 1 + 1 + int'(rstall[c]);
            end
            run_product(rstall, rdone, int'($urandom_range(2, 20)), 1'b1, $sformatf("rnd%0d", r));
        end

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
